// File: rtl/slave_rq_ack_pkg.sv
// Shared types for the req/ack shift-add multiplier slave.
// Holds the FSM state encoding and the operand width derivation.
package slave_rq_ack_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Each operand is half of the request word.
  function automatic int op_width(input int req_w);
    return req_w / 2;
  endfunction

endpackage

// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath: operand regs, accumulator, step counter.
// Ports: i_load latches operands, i_step does one step, o_last/o_product.
module mult_datapath
  import slave_rq_ack_pkg::*;
#(
  parameter int OP_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_load,
  input  logic                    i_step,
  input  logic [OP_WIDTH-1:0]     i_op1,
  input  logic [OP_WIDTH-1:0]     i_op2,
  output logic                    o_last,
  output logic [2*OP_WIDTH-1:0]   o_product
);

  localparam int PW = 2 * OP_WIDTH;
  localparam int CW = $clog2(OP_WIDTH + 1);

  logic [PW-1:0]       r_op1;
  logic [PW-1:0]       r_acc;
  logic [OP_WIDTH-1:0] r_op2;
  logic [CW-1:0]       r_cnt;
  logic [PW-1:0]       w_acc_nxt;

  // Result of the step taking place at the coming edge; on the last
  // step this is the finished product.
  assign w_acc_nxt = r_op2[0] ? r_acc + r_op1 : r_acc;
  assign o_product = w_acc_nxt;
  assign o_last    = (r_cnt == CW'(OP_WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op1 <= '0;
      r_op2 <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_op1 <= {{OP_WIDTH{1'b0}}, i_op1};
      r_op2 <= i_op2;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_step) begin
      r_acc <= w_acc_nxt;
      r_op1 <= r_op1 << 1;
      r_op2 <= r_op2 >> 1;
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/slave_rq_ack_mult.sv
// Request/acknowledge slave returning op1*op2 via a shift-add datapath.
// Ports: clk, rst, req/start/req_data in; ack/ack_data/busy/err out.
module slave_rq_ack_mult
  import slave_rq_ack_pkg::*;
#(
  parameter int REQDATA_WIDTH = 16,
  parameter int ACKDATA_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  input  logic                     start,
  input  logic [REQDATA_WIDTH-1:0] req_data,
  output logic                     ack,
  output logic [ACKDATA_WIDTH-1:0] ack_data,
  output logic                     busy,
  output logic                     err
);

  localparam int OP_WIDTH = op_width(REQDATA_WIDTH);

  generate
    if (ACKDATA_WIDTH < REQDATA_WIDTH) begin : g_bad_ackw
      $error("ACKDATA_WIDTH must be >= REQDATA_WIDTH");
    end
    if ((REQDATA_WIDTH % 2) != 0 || REQDATA_WIDTH < 4 ||
        REQDATA_WIDTH > 32) begin : g_bad_reqw
      $error("REQDATA_WIDTH must be even, 4..32");
    end
  endgenerate

  state_e                   r_state;
  logic                     r_ack;
  logic                     r_busy;
  logic                     r_err;
  logic [ACKDATA_WIDTH-1:0] r_ack_data;

  logic                     w_load;
  logic                     w_step;
  logic                     w_last;
  logic [REQDATA_WIDTH-1:0] w_product;
  logic                     w_unused;

  // start carries no meaning for this slave.
  assign w_unused = start;

  assign w_load = (r_state == IDLE) && req;
  assign w_step = (r_state == CALC) && req;

  mult_datapath #(
    .OP_WIDTH (OP_WIDTH)
  ) u_dp (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_step    (w_step),
    .i_op1     (req_data[REQDATA_WIDTH-1 -: OP_WIDTH]),
    .i_op2     (req_data[OP_WIDTH-1:0]),
    .o_last    (w_last),
    .o_product (w_product)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ack      <= 1'b0;
      r_ack_data <= '0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (req) begin
            r_state <= CALC;
            r_busy  <= 1'b1;
          end
        end
        CALC: begin
          if (!req) begin
            // Master withdrew mid-operation.
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end else if (w_last) begin
            r_state    <= DONE;
            r_ack      <= 1'b1;
            r_ack_data <= ACKDATA_WIDTH'(w_product);
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ack      = r_ack;
  assign ack_data = r_ack_data;
  assign busy     = r_busy;
  assign err      = r_err;

endmodule
